// File: rtl/stage_cfg_loader.sv
// stage_cfg_loader: control-plane loader for one match-action stage.
// Filters a shared word-serial config stream by stage ID, assembles wide
// key/mask or action entries and issues one-cycle write strobes toward
// lookup_engine.
// Optional build macro STAGE_CFG_STATS_EN adds saturating write/error counters.
module stage_cfg_loader #(
  parameter int KEY_LEN  = 896,
  parameter int MASK_LEN = 896,
  parameter int ACT_LEN  = 25,
  parameter int ADDR_W   = 4,
  parameter int STAGE_ID = 0
) (
  input  logic                axis_clk,
  input  logic                areset,
  input  logic [31:0]         cfg_data,
  input  logic                cfg_valid,
  input  logic                cfg_last,
  output logic                cfg_ready,
  output logic [KEY_LEN-1:0]  lookup_din,
  output logic [MASK_LEN-1:0] lookup_din_mask,
  output logic [ADDR_W-1:0]   lookup_din_addr,
  output logic                lookup_din_en,
  output logic [ACT_LEN-1:0]  action_data_in,
  output logic [ADDR_W-1:0]   action_addr,
  output logic                action_en,
  output logic                cfg_done,
  output logic                cfg_err
`ifdef STAGE_CFG_STATS_EN
  ,
  output logic [15:0]         stat_wr_cnt,
  output logic [15:0]         stat_err_cnt
`endif
);

  localparam int NK    = KEY_LEN / 32;
  localparam int CNT_W = $clog2(2 * NK + 1);
  localparam logic [CNT_W-1:0] KEY_WORDS = CNT_W'(NK);
  localparam logic [CNT_W-1:0] LK_FINAL  = CNT_W'(2 * NK - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_COMMIT = 2'd2,
    S_DROP   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic                r_readyEn;
  logic                r_err;
  logic                r_isAction;
  logic [ADDR_W-1:0]   r_addr;
  logic [CNT_W-1:0]    r_cnt;
  logic [KEY_LEN-1:0]  r_keyHold;
  logic [MASK_LEN-1:0] r_maskHold;
  logic [KEY_LEN-1:0]  r_lookupDin;
  logic [MASK_LEN-1:0] r_lookupMask;
  logic [ADDR_W-1:0]   r_lookupAddr;
  logic [ACT_LEN-1:0]  r_actData;
  logic [ADDR_W-1:0]   r_actAddr;

  logic                w_accept;
  logic                w_hdrMatch;
  logic                w_final;
  logic                w_errSet;
  logic                w_hdrLatch;
  logic                w_commitLoad;
  logic [KEY_LEN-1:0]  w_keyNext;
  logic [MASK_LEN-1:0] w_maskNext;

  // cfg_ready is gated by reset so the port reads 0 while areset is high,
  // and by the one-cycle-delayed enable so it rises the cycle after release.
  assign cfg_ready  = r_readyEn & ~areset & (r_state != S_COMMIT);
  assign w_accept   = cfg_valid & cfg_ready;
  assign w_hdrMatch = (cfg_data[31:28] == 4'(STAGE_ID)) && !cfg_data[27];
  assign w_final    = r_isAction ? (r_cnt == '0) : (r_cnt == LK_FINAL);

  // MSB-first packing: older words move up, the new word enters at the bottom.
  assign w_keyNext  = (r_keyHold << 32) | KEY_LEN'(cfg_data);
  assign w_maskNext = (r_maskHold << 32) | MASK_LEN'(cfg_data);

  assign lookup_din      = r_lookupDin;
  assign lookup_din_mask = r_lookupMask;
  assign lookup_din_addr = r_lookupAddr;
  assign action_data_in  = r_actData;
  assign action_addr     = r_actAddr;
  assign lookup_din_en   = (r_state == S_COMMIT) && !r_isAction;
  assign action_en       = (r_state == S_COMMIT) && r_isAction;
  assign cfg_done        = (r_state == S_COMMIT);
  assign cfg_err         = r_err;

  // State register.
  always_ff @(posedge axis_clk) begin
    if (areset) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  // Next-state decode plus the one-shot control decisions of each accepted word.
  always_comb begin
    w_nextState  = r_state;
    w_errSet     = 1'b0;
    w_hdrLatch   = 1'b0;
    w_commitLoad = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (!w_hdrMatch) begin
            if (!cfg_last) w_nextState = S_DROP;
          end else if (cfg_last) begin
            w_errSet = 1'b1;
          end else begin
            w_hdrLatch  = 1'b1;
            w_nextState = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (w_accept) begin
          if (w_final) begin
            if (cfg_last) begin
              w_commitLoad = 1'b1;
              w_nextState  = S_COMMIT;
            end else begin
              w_errSet    = 1'b1;
              w_nextState = S_DROP;
            end
          end else if (cfg_last) begin
            w_errSet    = 1'b1;
            w_nextState = S_IDLE;
          end
        end
      end
      S_COMMIT: w_nextState = S_IDLE;
      S_DROP: begin
        if (w_accept && cfg_last) w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Command context: ready enable, error pulse, latched type/address, word counter.
  always_ff @(posedge axis_clk) begin
    if (areset) begin
      r_readyEn  <= 1'b0;
      r_err      <= 1'b0;
      r_isAction <= 1'b0;
      r_addr     <= '0;
      r_cnt      <= '0;
    end else begin
      r_readyEn <= 1'b1;
      r_err     <= w_errSet;
      if (w_hdrLatch) begin
        r_isAction <= cfg_data[26];
        r_addr     <= cfg_data[ADDR_W-1:0];
        r_cnt      <= '0;
      end else if ((r_state == S_LOAD) && w_accept && !w_final) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Key and mask holding registers fill only while a lookup command loads.
  always_ff @(posedge axis_clk) begin
    if (areset) begin
      r_keyHold  <= '0;
      r_maskHold <= '0;
    end else if ((r_state == S_LOAD) && w_accept && !r_isAction) begin
      if (r_cnt < KEY_WORDS) r_keyHold  <= w_keyNext;
      else                   r_maskHold <= w_maskNext;
    end
  end

  // Output entries update only on a committed command and hold otherwise.
  always_ff @(posedge axis_clk) begin
    if (areset) begin
      r_lookupDin  <= '0;
      r_lookupMask <= '0;
      r_lookupAddr <= '0;
      r_actData    <= '0;
      r_actAddr    <= '0;
    end else if (w_commitLoad) begin
      if (r_isAction) begin
        r_actData <= cfg_data[ACT_LEN-1:0];
        r_actAddr <= r_addr;
      end else begin
        r_lookupDin  <= r_keyHold;
        r_lookupMask <= w_maskNext;
        r_lookupAddr <= r_addr;
      end
    end
  end

`ifdef STAGE_CFG_STATS_EN
  // Saturating counters of committed and rejected commands.
  always_ff @(posedge axis_clk) begin
    if (areset) begin
      stat_wr_cnt  <= '0;
      stat_err_cnt <= '0;
    end else begin
      if (cfg_done && (stat_wr_cnt != 16'hFFFF))  stat_wr_cnt  <= stat_wr_cnt + 16'd1;
      if (cfg_err && (stat_err_cnt != 16'hFFFF))  stat_err_cnt <= stat_err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/stage_cfg_loader.md
Name: stage_cfg_loader

Overview:
- Control-plane loader for one match-action stage.
- Receives a 32-bit word-serial configuration stream (header word followed by payload words), shared by all five stages.
- Keeps only commands whose stage ID matches STAGE_ID. Assembles the wide lookup key/mask entries or action entries, then issues single-cycle write strobes on the lookup_engine control channel (lookup_din*, action_*).
- Sits beside the stage, between the control stream demux and lookup_engine.

Parameters:
- KEY_LEN, 896, lookup key width; must be a multiple of 32.
- MASK_LEN, 896, lookup mask width; must equal KEY_LEN.
- ACT_LEN, 25, action RAM word width; must be ≤ 32.
- ADDR_W, 4, entry address width for both lookup and action RAM.
- STAGE_ID, 0, stage this instance serves; valid 0-4.

Ports:
- axis_clk  in  1  clock; all logic on rising edge.
- areset  in  1  reset, synchronous, active-high.
- cfg_data  in  32  configuration word.
- cfg_valid  in  1  cfg_data valid.
- cfg_last  in  1  last word of the command.
- cfg_ready  out  1  word accepted when cfg_valid and cfg_ready are both high.
- lookup_din  out  KEY_LEN  key entry to write.
- lookup_din_mask  out  MASK_LEN  mask entry to write.
- lookup_din_addr  out  ADDR_W  lookup entry address.
- lookup_din_en  out  1  one-cycle lookup write strobe.
- action_data_in  out  ACT_LEN  action entry to write.
- action_addr  out  ADDR_W  action entry address.
- action_en  out  1  one-cycle action write strobe.
- cfg_done  out  1  one-cycle pulse: command committed.
- cfg_err  out  1  one-cycle pulse: malformed command discarded.

Behaviour:
- Header word fields:
  - [31:28] stage ID.
  - [27:26] type: 00 = lookup, 01 = action, 1x = reserved.
  - [ADDR_W-1:0] address.
  - All other bits are ignored.
- Payload length:
  - Lookup: NK = KEY_LEN/32 key words, then NK mask words (56 at default).
  - Action: 1 word; the low ACT_LEN bits are used.
- Word packing: MSB-first. The first key word lands in lookup_din[KEY_LEN-1 -: 32]; the same rule applies to the mask.
- Reset values: every output is 0, cfg_ready included. The FSM goes to IDLE, and the counter and holding registers clear. cfg_ready rises the first cycle after areset deasserts.
- Reset mid-command: the partial command is discarded and no strobe is issued.
- FSM state IDLE (cfg_ready = 1). On an accepted header:
  - Stage ID ≠ STAGE_ID, or type reserved → DROP, with no error. If cfg_last is also set on the header, stay in IDLE.
  - Matching type with cfg_last set on the header → cfg_err pulse, stay in IDLE.
  - Otherwise latch type and address, clear the word counter → LOAD.
- FSM state LOAD (cfg_ready = 1). Each accepted word shifts into the key, mask or action holding register and increments the counter.
  - cfg_last before the final expected word → cfg_err pulse, → IDLE, no write.
  - Final expected word with cfg_last → COMMIT.
  - Final expected word without cfg_last → cfg_err pulse, → DROP.
- FSM state COMMIT (cfg_ready = 0, exactly one cycle):
  - Lookup command: drive lookup_din, lookup_din_mask and lookup_din_addr, and pulse lookup_din_en.
  - Action command: drive action_data_in and action_addr, and pulse action_en.
  - cfg_done pulses in the same cycle. Next state is IDLE.
  - Latency: the strobe is asserted in the cycle after the last word is accepted.
- FSM state DROP (cfg_ready = 1): discard words until an accepted word has cfg_last, then → IDLE.
- Output hold: data and address outputs hold their last committed values between commits. Only the holding registers change during LOAD.
- Flow control: cfg_valid low during any state simply stalls; the counter does not advance.
- Never are lookup_din_en and action_en high in the same cycle.
- Counter width: clog2(2*NK+1). The counter never wraps within one command.

Optional Feature:
- Macro: STAGE_CFG_STATS_EN.
- When defined, adds outputs stat_wr_cnt[15:0] and stat_err_cnt[15:0]:
  - stat_wr_cnt increments on each cfg_done.
  - stat_err_cnt increments on each cfg_err.
  - Both saturate at 16'hFFFF and reset to 0.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Action write: header 32'h0400_0005, then payload 32'h01AB_CDEF with cfg_last, at STAGE_ID = 0 → next cycle action_en = 1, action_addr = 5, action_data_in = 25'h1AB_CDEF, cfg_done = 1; lookup_din_en stays 0.
- Lookup write: header 32'h0000_0003, then 28 key words 32'hK0000000+i and 28 mask words 32'hFFFF_FFFF, last on word 56 → one-cycle lookup_din_en with addr 3, lookup_din[895:864] = 32'hK0000000, lookup_din_mask all ones; cfg_ready is low only during the strobe cycle.
- Foreign stage: header 32'h2000_0001 plus 3 words, last on the 3rd, at STAGE_ID = 0 → no strobe, no cfg_err, cfg_ready stays 1, and the next valid command commits normally.
- Early last: lookup header, then last on payload word 10 → cfg_err pulse, no lookup_din_en, outputs keep their previous values.
- Missing last: action header plus 3 payload words, last on the 3rd → cfg_err after word 1, words 2-3 dropped, no strobe; a following action command commits.
- Mid-command reset: areset for 1 cycle after 20 lookup payload words → all outputs 0, then cfg_ready = 1; the rest of the stream is taken as a new header, and no strobe fires from the old command.
